// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and ACK/NACK bit values for the I2C master
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP
    } i2c_mst_state_e;
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
endpackage

// File: rtl/i2c_bit_timer.sv
// i2c_bit_timer: quarter-bit and phase counters that pace every SCL bit
module i2c_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    output logic [1:0] phase,
    output logic       quarter_start,
    output logic       bit_end
);
    localparam int QW = $clog2(CLK_DIV);
    logic [QW-1:0] qcnt;
    logic          quarter_end;
    assign quarter_end   = qcnt == QW'(CLK_DIV - 1);
    assign quarter_start = qcnt == '0;
    assign bit_end       = quarter_end && phase == 2'd3 && !freeze;
    always_ff @(posedge clk) begin
        if (rst) begin
            qcnt  <= '0;
            phase <= 2'd0;
        end else if (!freeze) begin
            qcnt <= quarter_end ? '0 : qcnt + QW'(1);
            if (quarter_end) phase <= phase + 2'd1;
        end
    end
endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: byte-oriented I2C master running START, address, data bytes and STOP per command
module i2c_master_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 16,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_addr,
    input  logic             cmd_rw,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             scl,
    output logic             sda_out,
    output logic             oen,
    input  logic             sda_in
);
    import i2c_pkg::*;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);
    i2c_mst_state_e   state, nstate;
    logic [7:0]       sh;
    logic [2:0]       bcnt;
    logic [LEN_W-1:0] blen;
    logic             rw_q, samp, sda, need_load, freeze, shifting;
    logic [1:0]       phase;
    logic             quarter_start, bit_end;
    i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk(clk), .rst(rst), .freeze(freeze),
        .phase(phase), .quarter_start(quarter_start), .bit_end(bit_end)
    );
    // The first clk of every write byte is where tx data is taken; without data the bus waits there with scl low
    assign need_load = state == WR_DATA && bcnt == 3'd7 && phase == 2'd0 && quarter_start;
    assign freeze    = state == IDLE || (need_load && !tx_valid);
    assign tx_ready  = need_load && tx_valid;
    assign shifting  = state == ADDR || state == WR_DATA || state == RD_DATA;
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign scl       = state == IDLE || (state == START ? phase != 2'd3 : phase[1]);
    assign sda_out   = sda;
    assign oen       = sda;
    always_comb begin
        sda = 1'b1;
        case (state)
            START:   sda = !phase[1];
            ADDR:    sda = sh[7];
            WR_DATA: sda = need_load ? (!tx_valid || tx_data[7]) : sh[7];
            RD_ACK:  sda = blen != '0 ? I2C_ACK : I2C_NACK;
            STOP:    sda = phase == 2'd3;
            default: sda = 1'b1;
        endcase
    end
    always_comb begin
        nstate = state;
        case (state)
            IDLE:     nstate = cmd_valid ? START : IDLE;
            START:    nstate = bit_end ? ADDR : START;
            ADDR:     nstate = bit_end && bcnt == 3'd0 ? ADDR_ACK : ADDR;
            ADDR_ACK: nstate = !bit_end ? ADDR_ACK :
                               (samp == I2C_NACK || blen == '0) ? STOP :
                               rw_q ? RD_DATA : WR_DATA;
            WR_DATA:  nstate = bit_end && bcnt == 3'd0 ? WR_ACK : WR_DATA;
            WR_ACK:   nstate = !bit_end ? WR_ACK :
                               (samp == I2C_NACK || blen == '0) ? STOP : WR_DATA;
            RD_DATA:  nstate = bit_end && bcnt == 3'd0 ? RD_ACK : RD_DATA;
            RD_ACK:   nstate = !bit_end ? RD_ACK : blen == '0 ? STOP : RD_DATA;
            STOP:     nstate = bit_end ? IDLE : STOP;
            default:  nstate = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh       <= '0;
            bcnt     <= '0;
            blen     <= '0;
            rw_q     <= 1'b0;
            samp     <= 1'b1;
            err      <= 1'b0;
            done     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            state    <= nstate;
            done     <= state == STOP && bit_end;
            rx_valid <= 1'b0;
            if (state == IDLE && cmd_valid) begin
                sh   <= {cmd_addr, cmd_rw};
                rw_q <= cmd_rw;
                bcnt <= 3'd7;
                blen <= cmd_len > MAX_LEN ? MAX_LEN : cmd_len;
                err  <= 1'b0;
            end
            if (phase == 2'd3 && quarter_start) begin
                samp <= sda_in;
                if (state == RD_DATA) sh <= {sh[6:0], sda_in};
            end
            if (tx_ready) sh <= tx_data;
            // bcnt wraps 0 -> 7 so every byte starts at bit 7 without an explicit reload
            if (bit_end && shifting) begin
                bcnt <= bcnt - 3'd1;
                if (state != RD_DATA) sh <= {sh[6:0], 1'b1};
                if (bcnt == 3'd0 && state != ADDR) blen <= blen - LEN_W'(1);
                if (bcnt == 3'd0 && state == RD_DATA) begin
                    rx_data  <= sh;
                    rx_valid <= 1'b1;
                end
            end
            if (bit_end && (state == ADDR_ACK || state == WR_ACK) && samp == I2C_NACK) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed transactions against a bench-side I2C slave and bus decoder
module tb_i2c_master_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [4:0] cmd_len = '0;
    logic [7:0] tx_data = '0, rx_data;
    logic       tx_valid = 1'b0, tx_ready, rx_valid, busy, done, err, scl, sda_out, oen, sda_in;
    logic       slave_sda = 1'b1;
    logic [7:0] wr_bytes[32];
    logic [7:0] rd_bytes[16];
    logic [7:0] rx_got[16];
    logic       bits[512];
    int         total = 0, bad = 0;
    int         nfall, cur, tx_cnt, rx_cnt, stall_hi, cycles;
    bit         start_seen, stop_seen;
    i2c_master_ctrl #(.CLK_DIV(4), .MAX_BYTES(16), .LEN_W(5)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .err(err),
        .scl(scl), .sda_out(sda_out), .oen(oen), .sda_in(sda_in)
    );
    always #5 clk = ~clk;
    assign sda_in = (oen ? 1'b1 : sda_out) & slave_sda;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic line_now();
        return (oen ? 1'b1 : sda_out) & slave_sda;
    endfunction
    function automatic logic [7:0] byte_at(input int base);
        logic [7:0] b = '0;
        for (int i = 0; i < 8; i++) b = {b[6:0], bits[base + i]};
        return b;
    endfunction
    function automatic logic slave_bit(input int c, input logic rw, input int len, input bit nack);
        int k, j;
        if (nack) return 1'b1;
        if (c == 8) return 1'b0;
        if (c < 9 || c >= 9 + 9 * len) return 1'b1;
        k = (c - 9) % 9;
        j = (c - 9) / 9;
        if (k == 8) return rw ? 1'b1 : 1'b0;
        return rw ? rd_bytes[j][7 - k] : 1'b1;
    endfunction
    task automatic run_txn(input logic [6:0] a, input logic rw, input logic [4:0] len,
                           input int gate, input bit nack, input int rst_at, input int poke);
        int n, idx, el;
        logic pscl, pline, ln, prev_rdy;
        el = len > 16 ? 16 : int'(len);
        @(posedge clk); #1;
        cmd_addr = a; cmd_rw = rw; cmd_len = len; cmd_valid = 1'b1;
        tx_valid = 1'b0; slave_sda = 1'b1;
        start_seen = 0; stop_seen = 0; nfall = 0; cur = 0;
        tx_cnt = 0; rx_cnt = 0; stall_hi = 0; cycles = -1;
        for (int i = 0; i < 512; i++) bits[i] = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #1 check("accept", {busy, cmd_ready, err}, 3'b100);
        n = 0; idx = 0; prev_rdy = 0; pscl = 1; pline = 1;
        while (n < 4000) begin
            @(posedge clk); n++; #1;
            if (prev_rdy && idx < 31) idx++;
            tx_data  = wr_bytes[idx];
            tx_valid = idx < el && (idx == 0 || n >= gate);
            if (n == poke) begin
                cmd_valid = 1'b1; cmd_addr = 7'h33; cmd_rw = 1'b1; cmd_len = 5'd5;
            end else cmd_valid = 1'b0;
            if (rst_at > 0 && n == rst_at) rst = 1'b1;
            #1;
            if (rst_at > 0 && n == rst_at + 1) begin
                check("rst_mid", {scl, oen, busy, cmd_ready, done, tx_ready}, 6'b110100);
                rst = 1'b0;
                break;
            end
            ln = line_now();
            if (pscl && scl && pline && !ln) begin start_seen = 1; nfall = 0; end
            if (pscl && scl && !pline && ln) stop_seen = 1;
            if (!pscl && scl) bits[cur] = ln;
            if (pscl && !scl) begin
                cur = nfall; nfall++;
                slave_sda = slave_bit(cur, rw, el, nack);
                ln = line_now();
            end
            prev_rdy = tx_ready;
            if (tx_ready) tx_cnt++;
            if (rx_valid && rx_cnt < 16) begin rx_got[rx_cnt] = rx_data; rx_cnt++; end
            if (gate > 0 && n >= 304 && n <= 354 && scl) stall_hi++;
            pscl = scl; pline = ln;
            if (done) begin cycles = n; break; end
        end
        tx_valid = 1'b0; cmd_valid = 1'b0; slave_sda = 1'b1;
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1 check("reset_out", {scl, sda_out, oen, busy, done, err, tx_ready, rx_valid, cmd_ready}, 9'b111000001);
        check("reset_rx", rx_data, 8'h00);
        rst = 1'b0;
        wr_bytes[0] = 8'hA5; wr_bytes[1] = 8'h3C;
        run_txn(7'h50, 1'b0, 5'd2, 0, 0, 0, -1);
        check("wr_cycles", cycles, 464);
        check("wr_start", start_seen, 1);
        check("wr_stop", stop_seen, 1);
        check("wr_addr", byte_at(0), 8'hA0);
        check("wr_d0", byte_at(9), 8'hA5);
        check("wr_d1", byte_at(18), 8'h3C);
        check("wr_acks", {bits[8], bits[17], bits[26]}, 3'b000);
        check("wr_txcnt", tx_cnt, 2);
        check("wr_nbits", nfall, 28);
        check("wr_end", {err, busy, cmd_ready}, 3'b001);
        @(posedge clk); #2 check("done_pulse", done, 0);
        rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33;
        run_txn(7'h50, 1'b1, 5'd3, 0, 0, 0, -1);
        check("rd_cycles", cycles, 608);
        check("rd_addr", byte_at(0), 8'hA1);
        check("rd_cnt", rx_cnt, 3);
        check("rd_b0", rx_got[0], 8'h11);
        check("rd_b1", rx_got[1], 8'h22);
        check("rd_b2", rx_got[2], 8'h33);
        check("rd_macks", {bits[17], bits[26], bits[35]}, 3'b001);
        check("rd_stop", stop_seen, 1);
        check("rd_err_tx", {err, 4'(tx_cnt)}, 5'b00000);
        wr_bytes[0] = 8'h01; wr_bytes[1] = 8'h02; wr_bytes[2] = 8'h03; wr_bytes[3] = 8'h04;
        run_txn(7'h7F, 1'b0, 5'd4, 0, 1, 0, -1);
        check("nack_cycles", cycles, 176);
        check("nack_err", err, 1);
        check("nack_tx", tx_cnt, 0);
        check("nack_nbits", nfall, 10);
        check("nack_stop", stop_seen, 1);
        repeat (5) @(posedge clk);
        #2 check("nack_sticky", err, 1);
        wr_bytes[0] = 8'h5A; wr_bytes[1] = 8'hC3;
        run_txn(7'h50, 1'b0, 5'd2, 354, 0, 0, -1);
        check("stall_cycles", cycles, 514);
        check("stall_scl", stall_hi, 0);
        check("stall_d0", byte_at(9), 8'h5A);
        check("stall_d1", byte_at(18), 8'hC3);
        check("stall_tx", tx_cnt, 2);
        run_txn(7'h50, 1'b0, 5'd2, 0, 0, 228, -1);
        check("rst_tx", tx_cnt, 1);
        wr_bytes[0] = 8'h96;
        run_txn(7'h50, 1'b0, 5'd1, 0, 0, 0, -1);
        check("post_rst_cycles", cycles, 320);
        check("post_rst_d0", byte_at(9), 8'h96);
        check("post_rst_err", err, 0);
        run_txn(7'h2A, 1'b0, 5'd0, 0, 0, 0, 50);
        check("probe_cycles", cycles, 176);
        check("probe_addr", byte_at(0), 8'h54);
        check("probe_ack_stop", {bits[8], stop_seen}, 2'b01);
        check("probe_tx", tx_cnt, 0);
        repeat (4) @(posedge clk);
        #2 check("probe_idle", {busy, cmd_ready}, 2'b01);
        for (int i = 0; i < 20; i++) wr_bytes[i] = 8'(i * 17 + 3);
        run_txn(7'h11, 1'b0, 5'd20, 0, 0, 0, -1);
        check("clamp_cycles", cycles, 2480);
        check("clamp_tx", tx_cnt, 16);
        check("clamp_last", byte_at(9 + 9 * 15), 8'd258);
        check("clamp_nbits", nfall, 154);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
